// File: rtl/param_serial_lock.sv
// rtl/param_serial_lock.sv - parametrised serial password lock with lockdown and atomic password update
//
// Ports:
//   CLK         clock, all state on rising edge
//   RST         asynchronous active-low reset
//   set_mode    level, sampled only with the first digit of a sequence
//   digit_valid strobe, digit accepted on a CLK edge where high
//   digit       digit value (DIGIT_W bits)
//   clear       synchronous abort of the sequence in progress (wins over digit_valid)
//   unlock      lock open
//   error       last attempt failed
//   warning     lockdown active
//   set_done    one-cycle pulse on password commit
//   fail_count  consecutive failures, saturating at MAX_FAIL
//   dbg_state   IDLE=0, VERIFY=1, SET=2, LOCKED=3
module param_serial_lock #(
    parameter int DIGIT_W  = 4,
    parameter int PW_LEN   = 4,
    parameter int MAX_FAIL = 3,
    parameter logic [PW_LEN*DIGIT_W-1:0] INIT_PW    = {4'd0, 4'd0, 4'd0, 4'd0},
    parameter logic [PW_LEN*DIGIT_W-1:0] ADMIN_CODE = {4'd9, 4'd2, 4'd1, 4'd0}
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            set_mode,
    input  logic                            digit_valid,
    input  logic [DIGIT_W-1:0]              digit,
    input  logic                            clear,
    output logic                            unlock,
    output logic                            error,
    output logic                            warning,
    output logic                            set_done,
    output logic [$clog2(MAX_FAIL+1)-1:0]   fail_count,
    output logic [1:0]                      dbg_state
);

    localparam int IDX_W  = $clog2(PW_LEN);
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);
    localparam int PW_W   = PW_LEN * DIGIT_W;

    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(PW_LEN - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
    localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_FAIL);
    localparam logic [FAIL_W-1:0] FAIL_ONE = FAIL_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_VERIFY = 2'd1,
        S_SET    = 2'd2,
        S_LOCKED = 2'd3
    } lockState_t;

    lockState_t         state, stateNext;
    logic [IDX_W-1:0]   idx, idxNext;
    logic               mismatch, mismatchNext;
    logic [PW_W-1:0]    pwReg, pwNext;
    logic [DIGIT_W-1:0] shadow [PW_LEN];
    logic [DIGIT_W-1:0] shadowNext [PW_LEN];
    logic               unlockNext, errorNext, warningNext, setDoneNext;
    logic [FAIL_W-1:0]  failNext, failInc;
    logic [DIGIT_W-1:0] refDigit;
    logic               misAcc;
    logic               isLast;

    assign dbg_state = state;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= S_IDLE;
            idx        <= '0;
            mismatch   <= 1'b0;
            pwReg      <= INIT_PW;
            for (int i = 0; i < PW_LEN; i++) begin
                shadow[i] <= '0;
            end
            unlock     <= 1'b0;
            error      <= 1'b0;
            warning    <= 1'b0;
            set_done   <= 1'b0;
            fail_count <= '0;
        end else begin
            state      <= stateNext;
            idx        <= idxNext;
            mismatch   <= mismatchNext;
            pwReg      <= pwNext;
            shadow     <= shadowNext;
            unlock     <= unlockNext;
            error      <= errorNext;
            warning    <= warningNext;
            set_done   <= setDoneNext;
            fail_count <= failNext;
        end
    end

    always_comb begin
        stateNext    = state;
        idxNext      = idx;
        mismatchNext = mismatch;
        pwNext       = pwReg;
        shadowNext   = shadow;
        unlockNext   = unlock;
        errorNext    = error;
        warningNext  = warning;
        setDoneNext  = 1'b0;
        failNext     = fail_count;

        // The admin sequence replaces the password as reference while locked.
        if (state == S_LOCKED) begin
            refDigit = ADMIN_CODE[int'(idx)*DIGIT_W +: DIGIT_W];
        end else begin
            refDigit = pwReg[int'(idx)*DIGIT_W +: DIGIT_W];
        end
        // mismatch is always 0 at idx 0, so accumulating is safe on the first digit too.
        misAcc  = mismatch | (digit != refDigit);
        isLast  = (idx == IDX_LAST);
        failInc = (fail_count == FAIL_MAX) ? fail_count : fail_count + FAIL_ONE;

        if (clear) begin
            case (state)
                S_VERIFY, S_SET: begin
                    stateNext    = S_IDLE;
                    idxNext      = '0;
                    mismatchNext = 1'b0;
                end
                S_LOCKED: begin
                    idxNext      = '0;
                    mismatchNext = 1'b0;
                end
                default: ;
            endcase
        end else if (digit_valid) begin
            case (state)
                S_IDLE: begin
                    errorNext = 1'b0;
                    idxNext   = IDX_ONE;
                    if (set_mode && unlock) begin
                        shadowNext[0] = digit;
                        stateNext     = S_SET;
                    end else begin
                        unlockNext   = 1'b0;
                        mismatchNext = (digit != pwReg[DIGIT_W-1:0]);
                        stateNext    = S_VERIFY;
                    end
                end
                S_VERIFY: begin
                    if (isLast) begin
                        idxNext      = '0;
                        mismatchNext = 1'b0;
                        if (!misAcc) begin
                            unlockNext = 1'b1;
                            failNext   = '0;
                            stateNext  = S_IDLE;
                        end else begin
                            errorNext = 1'b1;
                            failNext  = failInc;
                            if (failInc == FAIL_MAX) begin
                                warningNext = 1'b1;
                                stateNext   = S_LOCKED;
                            end else begin
                                stateNext = S_IDLE;
                            end
                        end
                    end else begin
                        idxNext      = idx + IDX_ONE;
                        mismatchNext = misAcc;
                    end
                end
                S_SET: begin
                    if (isLast) begin
                        // Commit shadow plus the final digit in a single edge.
                        for (int i = 0; i < PW_LEN; i++) begin
                            if (i == PW_LEN - 1) begin
                                pwNext[i*DIGIT_W +: DIGIT_W] = digit;
                            end else begin
                                pwNext[i*DIGIT_W +: DIGIT_W] = shadow[i];
                            end
                        end
                        setDoneNext = 1'b1;
                        idxNext     = '0;
                        stateNext   = S_IDLE;
                    end else begin
                        shadowNext[idx] = digit;
                        idxNext         = idx + IDX_ONE;
                    end
                end
                S_LOCKED: begin
                    if (isLast) begin
                        idxNext      = '0;
                        mismatchNext = 1'b0;
                        if (!misAcc) begin
                            warningNext = 1'b0;
                            errorNext   = 1'b0;
                            failNext    = '0;
                            stateNext   = S_IDLE;
                        end else begin
                            failNext = FAIL_MAX;
                        end
                    end else begin
                        idxNext      = idx + IDX_ONE;
                        mismatchNext = misAcc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/param_serial_lock.md
Name: param_serial_lock

Overview:
- Parametrised serial password lock. Digits arrive one per valid strobe and are checked against a stored PW_LEN-digit password.
- Consecutive failures are counted. The block locks down after MAX_FAIL failures and releases only on a fixed admin sequence.
- While the lock is open, a new password can be programmed serially. The password is committed atomically through a shadow buffer.
- Sits between the keypad front end and the indicator lights of the lock top level.

Parameters:
DIGIT_W, 4, bits per digit
PW_LEN, 4, digits per password and per admin sequence (>=2)
MAX_FAIL, 3, consecutive failed attempts that trigger lockdown (>=1)
INIT_PW, {4'd0,4'd0,4'd0,4'd0}, PW_LEN*DIGIT_W packed reset password; digit 0 in the LSBs
ADMIN_CODE, {4'd9,4'd2,4'd1,4'd0}, PW_LEN*DIGIT_W packed admin release sequence; digit 0 in the LSBs (sequence 0,1,2,9)

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  reset, asynchronous, active-low
set_mode  in  1  level; sampled only at the first digit of a sequence
digit_valid  in  1  strobe; digit accepted on a CLK edge where high
digit  in  DIGIT_W  digit value
clear  in  1  synchronous abort of the sequence in progress
unlock  out  1  lock open
error  out  1  last attempt failed
warning  out  1  lockdown active
set_done  out  1  one-cycle pulse on password commit
fail_count  out  $clog2(MAX_FAIL+1)  consecutive failures, saturating at MAX_FAIL
dbg_state  out  2  IDLE=0, VERIFY=1, SET=2, LOCKED=3

Behaviour:
- Reset values:
  - unlock=0, error=0, warning=0, set_done=0, fail_count=0.
  - State=IDLE, idx=0, mismatch=0.
  - Password store = INIT_PW.
- All outputs are registered. A result is visible the cycle after the edge that accepts the last digit.
- Cycles without digit_valid never change state.
- IDLE:
  - Any accepted digit clears error and unlock. A new attempt always relocks.
  - Exception: if set_mode=1 and unlock=1, the digit is written to shadow[0], unlock stays 1, next state is SET, idx=1.
  - Otherwise: mismatch = (digit != pw[0]), next state is VERIFY, idx=1.
  - set_mode=1 while locked shut is treated as a normal verify.
- VERIFY:
  - Each digit: mismatch |= (digit != pw[idx]); idx++.
  - The full PW_LEN digits are always consumed. There is no early reject, so timing reveals nothing.
  - On digit PW_LEN-1:
    - Match: unlock=1, fail_count=0, go to IDLE.
    - Mismatch: error=1, fail_count++.
    - If the new fail_count == MAX_FAIL: warning=1, go to LOCKED. Otherwise go to IDLE.
- SET:
  - Each digit goes to shadow[idx]; idx++.
  - On digit PW_LEN-1: pw <= shadow with the last digit included, all in one edge.
  - set_done=1 for exactly one cycle, unlock stays 1, go to IDLE.
  - set_mode is ignored after the first digit.
- LOCKED:
  - unlock=0. set_mode is ignored.
  - Digits are compared against ADMIN_CODE with the same accumulate-over-PW_LEN rule as VERIFY.
  - Admin match: warning=0, error=0, fail_count=0, go to IDLE.
  - Admin mismatch: stay LOCKED, idx=0, fail_count held at MAX_FAIL.
- clear:
  - In VERIFY or SET: go to IDLE with idx=0 and mismatch=0. The shadow is discarded, pw is unchanged, fail_count is unchanged.
  - In LOCKED: idx=0, state stays LOCKED.
  - In IDLE: no effect.
  - clear and digit_valid in the same cycle: clear wins and the digit is dropped.
- Wrap and width rules:
  - idx width is $clog2(PW_LEN).
  - idx returns to 0 at every sequence end and never wraps mid-sequence.
  - fail_count never exceeds MAX_FAIL.
- Asynchronous reset mid-sequence or mid-SET restores INIT_PW. A partially written shadow never reaches pw.

Test Plan:
- Reset, then enter 0,0,0,0 -> unlock=1 one cycle after the 4th digit; error=0, fail_count=0.
- Unlocked: hold set_mode=1, enter 3,1,4,1 -> set_done one-cycle pulse; then enter 0,0,0,0 -> error=1, fail_count=1; then enter 3,1,4,1 -> unlock=1, fail_count=0.
- Enter wrong codes 1,1,1,1 three times -> fail_count goes 1,2,3, warning=1, dbg_state=3. Then enter the correct password -> unlock stays 0. Then enter 0,1,2,9 -> warning=0, fail_count=0, dbg_state=0.
- Unlocked SET: enter 7,7 then clear=1 (asserted with a third digit_valid in the same cycle) -> IDLE, set_done stays 0; the old password 0,0,0,0 still unlocks.
- Enter wrong 0,0,0 then assert reset mid-sequence -> all outputs 0, dbg_state=0, INIT_PW accepted afterwards.
- Re-parametrise with DIGIT_W=8, PW_LEN=6, MAX_FAIL=1 -> one wrong 6-digit code sets warning=1 immediately; the 6-digit ADMIN_CODE releases the lock.
